// File: rtl/powlib_pktfifo.sv
// Single-clock packet FIFO: beats are written speculatively and become visible to the
// reader only once the packet's last beat commits; open packets can be dropped.
module powlib_pktfifo #(
    parameter int unsigned W   = 16,
    parameter int unsigned D   = 8,
    parameter int unsigned NFS = 0,
    parameter int unsigned NES = 0,
    parameter string       ID  = "PFIFO"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           wrdata,
    input  logic                   wrvld,
    input  logic                   wrlast,
    input  logic                   wrdrop,
    output logic                   wrrdy,
    output logic                   wrnf,
    output logic                   wrerr,
    output logic [W-1:0]           rddata,
    output logic                   rdlast,
    output logic                   rdvld,
    input  logic                   rdrdy,
    output logic                   rdne,
    output logic [$clog2(D+1)-1:0] cnt
);

    localparam int unsigned PW    = $clog2(D);
    localparam int unsigned CW    = $clog2(D + 1);
    localparam int unsigned NfThr = D - NFS - 1;

    if (D < 2 || NFS + 1 > D || NES >= D) begin : g_param_check
        $fatal(1, "%s: illegal parameters (D=%0d NFS=%0d NES=%0d)", ID, D, NFS, NES);
    end

    logic [W:0]    mem [D];
    logic [PW-1:0] wrptr_q, wrptr_d;
    logic [PW-1:0] wrcmt_q, wrcmt_d;
    logic [PW-1:0] rdptr_q, rdptr_d;
    logic [CW-1:0] used_q, used_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrinc, rdinc, commit, drop, auto_drop, rdlast_raw;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // The whole FIFO is one open packet: it can never commit, so discard it.
        auto_drop = (used_q == CW'(D)) && (cnt_q == '0);
        wrrdy     = (used_q != CW'(D));
        rdvld     = (cnt_q != '0);
        wrinc     = wrvld & wrrdy;
        rdinc     = rdvld & rdrdy;
        drop      = wrdrop | auto_drop;
        commit    = wrinc & wrlast & ~drop;

        wrptr_d = wrptr_q;
        wrcmt_d = wrcmt_q;
        rdptr_d = rdptr_q;

        if (drop) begin
            wrptr_d = wrcmt_q;
        end else if (wrinc) begin
            wrptr_d = ptr_inc(wrptr_q);
        end
        if (commit) begin
            wrcmt_d = ptr_inc(wrptr_q);
        end
        if (rdinc) begin
            rdptr_d = ptr_inc(rdptr_q);
        end

        used_d = drop ? cnt_q - CW'(rdinc) : used_q + CW'(wrinc) - CW'(rdinc);
        // On commit every beat up to and including this one becomes readable.
        cnt_d  = (commit ? used_q + CW'(1) : cnt_q) - CW'(rdinc);

        {rdlast_raw, rddata} = mem[rdptr_q];
        rdlast = rdvld & rdlast_raw;
        wrerr  = auto_drop;
        wrnf   = (used_q >= CW'(NfThr));
        rdne   = (cnt_q <= CW'(NES));
        cnt    = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrptr_q <= '0;
            wrcmt_q <= '0;
            rdptr_q <= '0;
            used_q  <= '0;
            cnt_q   <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            wrcmt_q <= wrcmt_d;
            rdptr_q <= rdptr_d;
            used_q  <= used_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrinc) begin
            mem[wrptr_q] <= {wrlast, wrdata};
        end
    end

endmodule

// File: tb/tb_powlib_pktfifo.sv
// Randomised bench for powlib_pktfifo: a queue-based packet model (committed and open
// beats) is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_powlib_pktfifo;

    localparam int W   = 16;
    localparam int D   = 5;
    localparam int NFS = 1;
    localparam int NES = 1;
    localparam int CW  = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  wrdata;
    logic          wrvld, wrlast, wrdrop, rdrdy;
    logic          wrrdy, wrnf, wrerr, rdlast, rdvld, rdne;
    logic [W-1:0]  rddata;
    logic [CW-1:0] cnt;

    int n_checks  = 0;
    int n_fail    = 0;
    int dut_reads = 0;

    // Model: committed beats visible to the reader, and beats of the open packet.
    logic [W:0] comq[$];
    logic [W:0] pendq[$];

    powlib_pktfifo #(
        .W   (W),
        .D   (D),
        .NFS (NFS),
        .NES (NES),
        .ID  ("TBFIFO")
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .wrdata (wrdata),
        .wrvld  (wrvld),
        .wrlast (wrlast),
        .wrdrop (wrdrop),
        .wrrdy  (wrrdy),
        .wrnf   (wrnf),
        .wrerr  (wrerr),
        .rddata (rddata),
        .rdlast (rdlast),
        .rdvld  (rdvld),
        .rdrdy  (rdrdy),
        .rdne   (rdne),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Advance the model by one clock edge using the inputs presented this cycle.
    function automatic void model_step();
        int  used;
        int  c;
        bit  rd;
        bit  adrop;
        bit  wr;
        used  = comq.size() + pendq.size();
        c     = comq.size();
        rd    = (c != 0) && rdrdy;
        adrop = (used == D) && (c == 0);
        wr    = wrvld && (used != D);
        if (rd) void'(comq.pop_front());
        if (wrdrop || adrop) begin
            pendq.delete();
        end else if (wr) begin
            pendq.push_back({wrlast, wrdata});
            if (wrlast) begin
                foreach (pendq[i]) comq.push_back(pendq[i]);
                pendq.delete();
            end
        end
    endfunction

    task automatic cycle(input bit v, input bit l, input bit dr, input bit rr,
                         input logic [W-1:0] d);
        wrvld  = v;
        wrlast = l;
        wrdrop = dr;
        rdrdy  = rr;
        wrdata = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        int u;
        int c;
        if (rst) begin
            u = comq.size() + pendq.size();
            c = comq.size();
            chk("wrrdy", 32'(wrrdy), 32'(u != D));
            chk("wrerr", 32'(wrerr), 32'((u == D) && (c == 0)));
            chk("wrnf", 32'(wrnf), 32'(u >= D - NFS - 1));
            chk("rdvld", 32'(rdvld), 32'(c != 0));
            chk("rdne", 32'(rdne), 32'(c <= NES));
            chk("cnt", 32'(cnt), 32'(c));
            chk("rdlast", 32'(rdlast), (c != 0) ? 32'(comq[0][W]) : 32'd0);
            if (c != 0) chk("rddata", 32'(rddata), 32'(comq[0][W-1:0]));
            if (rdvld && rdrdy) dut_reads++;
        end
    end

    initial begin
        int sent;
        wrdata = '0;
        wrvld  = 1'b0;
        wrlast = 1'b0;
        wrdrop = 1'b0;
        rdrdy  = 1'b0;
        #1;
        chk("reset_wrrdy", 32'(wrrdy), 32'd1);
        chk("reset_rdvld", 32'(rdvld), 32'd0);
        chk("reset_rdlast", 32'(rdlast), 32'd0);
        chk("reset_wrnf", 32'(wrnf), 32'd0);
        chk("reset_wrerr", 32'(wrerr), 32'd0);
        chk("reset_rdne", 32'(rdne), 32'd1);
        chk("reset_cnt", 32'(cnt), 32'd0);
        #1 rst = 1'b1;

        // Three-beat packet is invisible until its last beat commits.
        cycle(1, 0, 0, 0, 16'hA001);
        cycle(1, 0, 0, 0, 16'hA002);
        chk("a_precommit_rdvld", 32'(rdvld), 32'd0);
        cycle(1, 1, 0, 0, 16'hA003);
        chk("a_cnt", 32'(cnt), 32'd3);
        chk("a_rddata", 32'(rddata), 32'hA001);
        cycle(0, 0, 0, 1, '0);
        chk("a_pop1_cnt", 32'(cnt), 32'd2);
        chk("a_pop1_rdne", 32'(rdne), 32'd0);
        cycle(0, 0, 0, 1, '0);
        chk("a_pop2_rdlast", 32'(rdlast), 32'd1);
        cycle(0, 0, 0, 1, '0);
        chk("a_empty_rdvld", 32'(rdvld), 32'd0);

        // Drop with a last beat in the same cycle discards the whole packet.
        cycle(1, 0, 0, 0, 16'hB001);
        cycle(1, 0, 0, 0, 16'hB002);
        cycle(1, 1, 1, 0, 16'hB003);
        chk("b_drop_cnt", 32'(cnt), 32'd0);
        chk("b_drop_rdvld", 32'(rdvld), 32'd0);
        cycle(1, 1, 0, 0, 16'hC001);
        chk("c_rddata", 32'(rddata), 32'hC001);
        chk("c_rdlast", 32'(rdlast), 32'd1);
        cycle(0, 0, 0, 1, '0);

        // Oversize packet: FIFO fills with one open packet and is auto-dropped.
        for (int i = 0; i < D; i++) begin
            cycle(1, 0, 0, 0, 16'hE000 + 16'(i));
            if (i == 2) chk("e_wrnf", 32'(wrnf), 32'd1);
        end
        chk("e_full_wrrdy", 32'(wrrdy), 32'd0);
        chk("e_wrerr", 32'(wrerr), 32'd1);
        cycle(1, 0, 0, 0, 16'hE005);
        chk("e_wrerr_clear", 32'(wrerr), 32'd0);
        chk("e_wrrdy_back", 32'(wrrdy), 32'd1);
        cycle(1, 1, 0, 0, 16'hE005);
        chk("e_newpkt_rddata", 32'(rddata), 32'hE005);
        chk("e_newpkt_cnt", 32'(cnt), 32'd1);
        cycle(0, 0, 0, 1, '0);

        // Twelve one-beat packets with random read back-pressure, across pointer wrap.
        dut_reads = 0;
        sent      = 0;
        for (int k = 0; k < 80 && (sent < 12 || comq.size() != 0); k++) begin
            bit v;
            v = (sent < 12);
            if (v && (comq.size() + pendq.size() != D)) begin
                sent++;
                cycle(1, 1, 0, ($urandom % 2) == 1, 16'h1000 + 16'(sent));
            end else begin
                cycle(v, 1, 0, ($urandom % 2) == 1, 16'h1000 + 16'(sent + 1));
            end
        end
        chk("onebeat_reads", 32'(dut_reads), 32'd12);

        repeat (500) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 20) == 0,
                  ($urandom % 2) == 1, W'($urandom));
        end

        // Asynchronous reset mid-packet with committed data present.
        repeat (8) cycle(0, 0, 1, 1, '0);
        cycle(1, 1, 0, 0, 16'hF001);
        cycle(1, 1, 0, 0, 16'hF002);
        cycle(1, 0, 0, 0, 16'hF003);
        chk("f_cnt", 32'(cnt), 32'd2);
        wrvld = 1'b0;
        wrlast = 1'b0;
        rst = 1'b0;
        #1;
        chk("f_rst_rdvld", 32'(rdvld), 32'd0);
        chk("f_rst_cnt", 32'(cnt), 32'd0);
        chk("f_rst_wrrdy", 32'(wrrdy), 32'd1);
        chk("f_rst_rdne", 32'(rdne), 32'd1);
        chk("f_rst_rdlast", 32'(rdlast), 32'd0);
        comq.delete();
        pendq.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1, 1, 0, 0, 16'hF004);
        chk("f_post_rddata", 32'(rddata), 32'hF004);
        chk("f_post_cnt", 32'(cnt), 32'd1);
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
